// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - parametrised sequential ALU with valid/ready handshakes
// Single-cycle ops resolve at accept; SLL and MUL iterate in EXEC before HOLD.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_is_mul;
    logic [WIDTH-1:0]     r_sh;
    logic [WIDTH-1:0]     r_mc;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;

    logic                 w_accept;
    logic [SHW-1:0]       w_shamt;
    logic [WIDTH:0]       w_sum_add;
    logic [WIDTH:0]       w_sum_sub;
    logic                 w_slt;
    logic [WIDTH:0]       w_mstep;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_load;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_shamt   = b[SHW-1:0];

    assign w_sum_add = {1'b0, a} + {1'b0, b};
    assign w_sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_slt     = $signed(a) < $signed(b);

    // Right-shifting shift-add: the multiplier occupies the low half and drains out as the product fills in
    assign w_mstep    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mc & {WIDTH{r_acc[0]}}};
    assign w_acc_next = {w_mstep, r_acc[WIDTH-1:1]};

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (op == OP_MUL || (op == OP_SLL && w_shamt != '0)) begin
                        w_next = S_EXEC;
                    end else begin
                        w_next = S_HOLD;
                        w_load = 1'b1;
                        case (op)
                            OP_ADD: begin
                                w_res = w_sum_add[WIDTH-1:0];
                                w_c   = w_sum_add[WIDTH];
                                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum_add[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_SUB: begin
                                w_res = w_sum_sub[WIDTH-1:0];
                                w_c   = w_sum_sub[WIDTH];
                                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sum_sub[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_AND:  w_res = a & b;
                            OP_OR:   w_res = a | b;
                            OP_XOR:  w_res = a ^ b;
                            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
                            OP_SLL:  w_res = a;
                            default: w_res = '0;
                        endcase
                    end
                end
            end
            S_EXEC: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_HOLD;
                    w_load = 1'b1;
                    if (r_is_mul) begin
                        w_res = w_acc_next[WIDTH-1:0];
                        w_c   = |w_acc_next[2*WIDTH-1:WIDTH];
                        w_v   = |w_acc_next[2*WIDTH-1:WIDTH];
                    end else begin
                        w_res = {r_sh[WIDTH-2:0], 1'b0};
                        w_c   = r_sh[WIDTH-1];
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_is_mul <= 1'b0;
            r_sh     <= '0;
            r_mc     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_accept) begin
                r_is_mul <= (op == OP_MUL);
                r_sh     <= a;
                r_mc     <= b;
                r_acc    <= {{WIDTH{1'b0}}, a};
                r_cnt    <= (op == OP_MUL) ? CW'(WIDTH) : {1'b0, w_shamt};
            end else if (r_state == S_EXEC) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_is_mul) begin
                    r_acc <= w_acc_next;
                end else begin
                    r_sh <= {r_sh[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (w_load) begin
            result   <= w_res;
            zero     <= (w_res == '0);
            negative <= w_res[WIDTH-1];
            carry    <= w_c;
            overflow <= w_v;
        end
    end
endmodule
